// File: rtl/line_buffer_win_if.sv
// ============================================================================
// Module      : line_buffer_win_if
// Description : Handshake/data bundle between a pixel producer/consumer and
//               line_buffer_win.
//               master : the control stage (drives writes and read strobes)
//               slave  : the line buffer itself
//   i_data        write pixel
//   i_data_valid  write request
//   o_wr_ready    buffer is filling and accepts writes
//   i_rd_data     read/advance request
//   o_line_ready  a full line is stored and can be drained
//   o_data        WIN-tap window, tap 0 in the MSBs
//   o_data_valid  o_data/o_col updated this cycle
//   o_col         column of tap 0 for the current o_data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_buffer_win_if #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int WIN      = 3
);
  localparam int ADDR_W = $clog2(LINE_LEN);

  logic [DATA_W-1:0]     i_data;
  logic                  i_data_valid;
  logic                  o_wr_ready;
  logic                  i_rd_data;
  logic                  o_line_ready;
  logic [WIN*DATA_W-1:0] o_data;
  logic                  o_data_valid;
  logic [ADDR_W-1:0]     o_col;

  modport master (
    output i_data, i_data_valid, i_rd_data,
    input  o_wr_ready, o_line_ready, o_data, o_data_valid, o_col
  );

  modport slave (
    input  i_data, i_data_valid, i_rd_data,
    output o_wr_ready, o_line_ready, o_data, o_data_valid, o_col
  );
endinterface

`default_nettype wire

// File: rtl/line_buffer_win.sv
// ============================================================================
// Module      : line_buffer_win
// Description : Single-line pixel buffer for the sliding-window datapath.
//               FILL: stores LINE_LEN pixels through a valid/ready write
//               handshake. DRAIN: each accepted read strobe produces one
//               registered WIN-pixel window (1-cycle latency), then the
//               buffer returns to FILL after the last column.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - synchronous active-high reset
//               bus    - line_buffer_win_if.slave (pixel write handshake,
//                        read strobe, window output, status flags)
// Build option: LINE_BUFFER_WIN_EDGE_REPLICATE_EN
//               defined   -> taps past the line end repeat the last pixel
//               undefined -> taps past the line end wrap to column 0 onward
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer_win #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int WIN      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  line_buffer_win_if.slave  bus
);

  localparam int ADDR_W = $clog2(LINE_LEN);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  // Line length at ADDR_W+1 bits so rd_col+k never truncates before compare.
  localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W + 1)'(LINE_LEN);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     wr_col_q;
  logic [ADDR_W-1:0]     rd_col_q;
  logic                  wr_ready_q;
  logic                  line_ready_q;
  logic [WIN*DATA_W-1:0] data_q;
  logic                  data_valid_q;
  logic [ADDR_W-1:0]     col_q;

  logic [DATA_W-1:0]     mem_q [LINE_LEN];

  logic [WIN*DATA_W-1:0] window_d;
  logic [ADDR_W:0]       tap_idx;
  logic [ADDR_W-1:0]     tap_col;

  // Line storage: not cleared by reset; written only while filling.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_q == S_FILL && bus.i_data_valid) begin
      mem_q[wr_col_q] <= bus.i_data;
    end
  end

  // Window gather for the current read column, including line-end mapping.
  always_comb begin
    window_d = '0;
    tap_idx  = '0;
    tap_col  = '0;
    for (int k = 0; k < WIN; k++) begin
      tap_idx = {1'b0, rd_col_q} + (ADDR_W + 1)'(k);
      if (tap_idx >= LEN_EXT) begin
`ifdef LINE_BUFFER_WIN_EDGE_REPLICATE_EN
        tap_col = LAST_COL;
`else
        tap_col = ADDR_W'(tap_idx - LEN_EXT);
`endif
      end else begin
        tap_col = tap_idx[ADDR_W-1:0];
      end
      window_d[(WIN-1-k)*DATA_W +: DATA_W] = mem_q[tap_col];
    end
  end

  // FILL/DRAIN sequencing with registered status and window outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_FILL;
      wr_col_q     <= '0;
      rd_col_q     <= '0;
      wr_ready_q   <= 1'b1;
      line_ready_q <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      col_q        <= '0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (bus.i_data_valid) begin
            if (wr_col_q == LAST_COL) begin
              wr_col_q     <= '0;
              state_q      <= S_DRAIN;
              wr_ready_q   <= 1'b0;
              line_ready_q <= 1'b1;
            end else begin
              wr_col_q <= wr_col_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (bus.i_rd_data) begin
            data_valid_q <= 1'b1;
            data_q       <= window_d;
            col_q        <= rd_col_q;
            if (rd_col_q == LAST_COL) begin
              rd_col_q     <= '0;
              state_q      <= S_FILL;
              wr_ready_q   <= 1'b1;
              line_ready_q <= 1'b0;
            end else begin
              rd_col_q <= rd_col_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q      <= S_FILL;
          wr_ready_q   <= 1'b1;
          line_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_wr_ready   = wr_ready_q;
  assign bus.o_line_ready = line_ready_q;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = data_valid_q;
  assign bus.o_col        = col_q;

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_win.sv
// ============================================================================
// Module      : tb_line_buffer_win
// Description : Self-checking bench for line_buffer_win. Two instances:
//               index 0 -> LINE_LEN=8, index 1 -> LINE_LEN=5 (WIN=3, 8-bit).
//               A line-level model predicts every output each cycle; literal
//               windows pin the model. Honours LINE_BUFFER_WIN_EDGE_REPLICATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_buffer_win;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_win_if #(.DATA_W(8), .LINE_LEN(8), .WIN(3)) if8 ();
  line_buffer_win_if #(.DATA_W(8), .LINE_LEN(5), .WIN(3)) if5 ();

  line_buffer_win #(.DATA_W(8), .LINE_LEN(8), .WIN(3)) u_dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if8.slave)
  );

  line_buffer_win #(.DATA_W(8), .LINE_LEN(5), .WIN(3)) u_dut5 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if5.slave)
  );

  logic       dv8 = 1'b0, rd8 = 1'b0, dv5 = 1'b0, rd5 = 1'b0;
  logic [7:0] d8 = '0, d5 = '0;

  assign if8.i_data_valid = dv8;
  assign if8.i_data       = d8;
  assign if8.i_rd_data    = rd8;
  assign if5.i_data_valid = dv5;
  assign if5.i_data       = d5;
  assign if5.i_rd_data    = rd5;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- line-level model ----------------
  logic [7:0]  m_line [2][8];
  int          m_len  [2] = '{8, 5};
  bit          m_drain[2] = '{0, 0};
  int          m_w    [2] = '{0, 0};
  int          m_r    [2] = '{0, 0};
  logic        e_valid[2] = '{0, 0};
  logic [23:0] e_data [2] = '{24'h0, 24'h0};
  logic [2:0]  e_col  [2] = '{3'h0, 3'h0};

  function automatic logic [23:0] exp_win(int i, int c);
    logic [23:0] r;
    int x;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      x = c + k;
      if (x >= m_len[i]) begin
`ifdef LINE_BUFFER_WIN_EDGE_REPLICATE_EN
        x = m_len[i] - 1;
`else
        x = x % m_len[i];
`endif
      end
      r[(2-k)*8 +: 8] = m_line[i][x];
    end
    return r;
  endfunction

  task automatic mdl_step(int i, logic dv, logic [7:0] d, logic rd);
    e_valid[i] = 1'b0;
    if (!m_drain[i]) begin
      if (dv) begin
        m_line[i][m_w[i]] = d;
        m_w[i]++;
        if (m_w[i] == m_len[i]) begin
          m_w[i] = 0;
          m_drain[i] = 1'b1;
        end
      end
    end else if (rd) begin
      e_valid[i] = 1'b1;
      e_col[i]   = 3'(m_r[i]);
      e_data[i]  = exp_win(i, m_r[i]);
      m_r[i]++;
      if (m_r[i] == m_len[i]) begin
        m_r[i] = 0;
        m_drain[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_drain[i] = 1'b0; m_w[i] = 0; m_r[i] = 0;
        e_valid[i] = 1'b0; e_data[i] = '0; e_col[i] = '0;
      end
    end else begin
      mdl_step(0, dv8, d8, rd8);
      mdl_step(1, dv5, d5, rd5);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("L8 valid",      32'(if8.o_data_valid), 32'(e_valid[0]));
    chk("L8 wr_ready",   32'(if8.o_wr_ready),   32'(!m_drain[0]));
    chk("L8 line_ready", 32'(if8.o_line_ready), 32'(m_drain[0]));
    chk("L8 data",       32'(if8.o_data),       32'(e_data[0]));
    chk("L8 col",        32'(if8.o_col),        32'(e_col[0]));
    chk("L5 valid",      32'(if5.o_data_valid), 32'(e_valid[1]));
    chk("L5 wr_ready",   32'(if5.o_wr_ready),   32'(!m_drain[1]));
    chk("L5 line_ready", 32'(if5.o_line_ready), 32'(m_drain[1]));
    chk("L5 data",       32'(if5.o_data),       32'(e_data[1]));
    chk("L5 col",        32'(if5.o_col),        32'(e_col[1]));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] exp8 [8];
  logic [23:0] exp5 [5];

  initial begin
    exp8[0] = 24'h101112; exp8[1] = 24'h111213; exp8[2] = 24'h121314;
    exp8[3] = 24'h131415; exp8[4] = 24'h141516; exp8[5] = 24'h151617;
    exp5[0] = 24'h010203; exp5[1] = 24'h020304; exp5[2] = 24'h030405;
`ifdef LINE_BUFFER_WIN_EDGE_REPLICATE_EN
    exp8[6] = 24'h161717; exp8[7] = 24'h171717;
    exp5[3] = 24'h040505; exp5[4] = 24'h050505;
`else
    exp8[6] = 24'h161710; exp8[7] = 24'h171011;
    exp5[3] = 24'h040501; exp5[4] = 24'h050102;
`endif

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst wr_ready",   32'(if8.o_wr_ready),   32'h1);
    chk("rst line_ready", 32'(if8.o_line_ready), 32'h0);
    chk("rst data",       32'(if8.o_data),       32'h0);
    chk("rst valid",      32'(if8.o_data_valid), 32'h0);
    chk("rst col",        32'(if8.o_col),        32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reads while filling are ignored
    rd8 = 1'b1; rd5 = 1'b1;
    tick(); chk("fill read no valid L8", 32'(if8.o_data_valid), 32'h0);
    tick(); chk("fill read no valid L5", 32'(if5.o_data_valid), 32'h0);
    rd8 = 1'b0; rd5 = 1'b0;

    // Fill: L8 gets 0x10..0x17, L5 gets 1..5
    for (int i = 0; i < 8; i++) begin
      dv8 = 1'b1; d8 = 8'(8'h10 + i);
      dv5 = (i < 5); d5 = 8'(i + 1);
      tick();
      if (i == 6) chk("L8 still filling", 32'(if8.o_wr_ready), 32'h1);
    end
    chk("L8 line_ready after fill", 32'(if8.o_line_ready), 32'h1);
    chk("L8 wr_ready after fill",   32'(if8.o_wr_ready),   32'h0);
    // Writes during drain must be dropped
    dv8 = 1'b1; d8 = 8'hFF;
    dv5 = 1'b1; d5 = 8'hFF;

    // First window alone, then check the pulse/hold behaviour
    rd8 = 1'b1; tick(); rd8 = 1'b0;
    chk("L8 first valid", 32'(if8.o_data_valid), 32'h1);
    chk("L8 win0",        32'(if8.o_data),       32'(exp8[0]));
    chk("L8 col0",        32'(if8.o_col),        32'h0);
    tick();
    chk("L8 valid pulse", 32'(if8.o_data_valid), 32'h0);
    chk("L8 data hold",   32'(if8.o_data),       32'(exp8[0]));

    // Remaining L8 windows back-to-back; L5 drains alongside
    for (int i = 1; i < 8; i++) begin
      rd8 = 1'b1;
      rd5 = (i <= 5);
      tick();
      chk($sformatf("L8 win%0d", i), 32'(if8.o_data), 32'(exp8[i]));
      chk($sformatf("L8 col%0d", i), 32'(if8.o_col),  32'(i));
      if (i <= 5) chk($sformatf("L5 win%0d", i-1), 32'(if5.o_data), 32'(exp5[i-1]));
      if (i == 5) chk("L5 back to fill", 32'(if5.o_wr_ready), 32'h1);
    end
    rd8 = 1'b0; rd5 = 1'b0;
    dv8 = 1'b0; dv5 = 1'b0;
    chk("L8 line_ready after drain", 32'(if8.o_line_ready), 32'h0);
    chk("L8 wr_ready after drain",   32'(if8.o_wr_ready),   32'h1);

    // Reset mid-drain, with a read in the reset cycle
    for (int i = 0; i < 8; i++) begin
      dv8 = 1'b1; d8 = 8'(8'h30 + i);
      tick();
    end
    dv8 = 1'b0;
    rd8 = 1'b1; tick(); tick(); tick();
    chk("L8 mid win2", 32'(if8.o_data), 32'h323334);
    rst = 1'b1;
    tick();
    rst = 1'b0; rd8 = 1'b0;
    chk("mid rst valid",      32'(if8.o_data_valid), 32'h0);
    chk("mid rst wr_ready",   32'(if8.o_wr_ready),   32'h1);
    chk("mid rst line_ready", 32'(if8.o_line_ready), 32'h0);
    chk("mid rst data",       32'(if8.o_data),       32'h0);

    // Refill 0x20..0x27 and read the first window
    for (int i = 0; i < 8; i++) begin
      dv8 = 1'b1; d8 = 8'(8'h20 + i);
      tick();
    end
    dv8 = 1'b0;
    rd8 = 1'b1; tick(); rd8 = 1'b0;
    chk("refill win0",  32'(if8.o_data),       32'h202122);
    chk("refill col0",  32'(if8.o_col),        32'h0);
    chk("refill valid", 32'(if8.o_data_valid), 32'h1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_buffer_win.md
Name: line_buffer_win

Overview:
- Parametrised single-line pixel buffer for the sliding-window (convolution) datapath.
- Captures one full image line of DATA_W-bit pixels, then drains it as WIN-pixel horizontal windows, one window per read strobe.
- Differences from the fixed 8-bit/512/3-tap line store: valid/ready write handshake, explicit FILL/DRAIN sequencing, a registered output with a valid flag, and defined line-end tap handling.
- Instantiated in parallel (one per kernel row) by the window/control stage.

Parameters:
- DATA_W, 8: pixel width in bits.
- LINE_LEN, 512: pixels per line. Legal range 2..4096; need not be a power of two.
- WIN, 3: taps per output window. Legal range 1..LINE_LEN.
- Derived localparam ADDR_W = $clog2(LINE_LEN).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  DATA_W  write pixel.
- i_data_valid  in  1  write request.
- o_wr_ready  out  1  buffer accepts writes (state FILL).
- i_rd_data  in  1  read/advance request.
- o_line_ready  out  1  full line stored (state DRAIN).
- o_data  out  WIN*DATA_W  window; tap 0 in the MSBs, tap WIN-1 in the LSBs.
- o_data_valid  out  1  o_data/o_col updated this cycle.
- o_col  out  ADDR_W  column of tap 0 for the current o_data.

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Storage: LINE_LEN x DATA_W array, addressed by column. Contents are not cleared by reset.
- State machine with two states, FILL and DRAIN. Reset state is FILL.
- Reset values: wr_col=0, rd_col=0, o_wr_ready=1, o_line_ready=0, o_data=0, o_data_valid=0, o_col=0.
- FILL:
  - o_wr_ready=1.
  - A write is accepted when i_data_valid=1: mem[wr_col] <= i_data.
  - On acceptance, wr_col increments; if wr_col == LINE_LEN-1, it wraps to 0 and the state moves to DRAIN.
  - i_rd_data is ignored; o_data_valid stays 0.
- DRAIN:
  - o_line_ready=1, o_wr_ready=0.
  - i_data_valid is ignored; the data is dropped and the memory is not written.
  - A read is accepted when i_rd_data=1. On the next cycle:
    - o_data_valid=1
    - o_col = rd_col
    - o_data tap k = mem[col(rd_col+k)]
  - After the read, rd_col increments. If rd_col == LINE_LEN-1, it wraps to 0 and the state moves to FILL; o_wr_ready=1 on the following cycle.
- Read latency: exactly 1 cycle from the accepted i_rd_data to o_data_valid. Back-to-back reads give one window per cycle.
- o_data_valid is a single-cycle pulse per accepted read. o_data and o_col hold their values between reads.
- Line-end tap mapping (for rd_col+k >= LINE_LEN): default col(x) = x - LINE_LEN, i.e. wrap to the start of the same line. See Optional Feature.
- Width rule: rd_col+k is computed at ADDR_W+1 bits before the compare, so there is no silent truncation when LINE_LEN is not a power of two.
- Simultaneous write and read: only the one matching the current state is honoured, so there is never a conflict.
- The final write and the DRAIN entry happen in the same edge. A read can be accepted from the next cycle.
- Reset mid-line, in either state: returns to FILL with the column counters at 0. A read accepted in the same cycle as reset yields no o_data_valid.
- WIN=1: o_data = mem[rd_col]; no line-end mapping occurs.

Optional Feature:
- Macro: LINE_BUFFER_WIN_EDGE_REPLICATE_EN.
- Defined: taps past the line end clamp, col(x) = LINE_LEN-1 (replicate the border pixel) for image-edge padding.
- Undefined: modulo wrap as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Bench config for all scenarios: LINE_LEN=8, WIN=3, DATA_W=8.
- Fill and first window: after reset, write 0x10..0x17 on consecutive cycles. o_wr_ready drops and o_line_ready rises the cycle after the 8th write. One read gives o_data=0x101112, o_col=0, with o_data_valid one cycle later.
- Full drain with wrap: 8 back-to-back reads give windows 101112, 111213, ..., 151617, 161710, 171011. o_line_ready falls and o_wr_ready rises after the 8th read.
- Edge replicate: same stimulus with LINE_BUFFER_WIN_EDGE_REPLICATE_EN defined. The last two windows are 0x161717 and 0x171717.
- Illegal requests: reads while in FILL give no o_data_valid. Writes of 0xFF while in DRAIN leave the drained windows unchanged.
- Reset mid-operation: assert i_rst after 3 reads in DRAIN. o_wr_ready=1, o_line_ready=0, o_data=0. Refilling with 0x20..0x27 and reading gives 0x202122 at o_col=0.
- Non-power-of-two: LINE_LEN=5, WIN=3, data 1..5. The reads give 010203, 020304, 030405, 040501, 050102, then back to FILL.
